// File: rtl/enc8b10b_lane.sv
// enc8b10b_lane: multi-byte 8b/10b encoder for one JESD204B transmit lane.
// Encodes BYTES octets per clock (byte 0 first on the wire) in D or K mode.
// Running disparity chains through every byte of a word and from one word
// to the next.
// Symbol layout: bit 10n+9 is 'a', so each symbol reads abcdeifghj MSB-first.
// Illegal K octets are replaced by K28.5 and flagged on o_k_error.
// Optional feature: define ENC_RD_LOAD_EN to add i_rd_load/i_rd_value, which
// let the framer force the running disparity.

module enc8b10b_lane #(
  parameter int BYTES   = 4,
  parameter int REG_OUT = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_valid,
  input  logic [8*BYTES-1:0]   i_data,
  input  logic [BYTES-1:0]     i_k,
`ifdef ENC_RD_LOAD_EN
  input  logic                 i_rd_load,
  input  logic                 i_rd_value,
`endif
  output logic                 o_valid,
  output logic [10*BYTES-1:0]  o_data,
  output logic [BYTES-1:0]     o_k_error,
  output logic                 o_rd
);

  // Only K28.y and the four x.7 specials (K23/27/29/30.7) are legal controls.
  function automatic logic k_is_legal(input logic [7:0] octet);
    logic [4:0] x;
    x = octet[4:0];
    return (x == 5'd28) ||
           ((octet[7:5] == 3'd7) &&
            ((x == 5'd23) || (x == 5'd27) || (x == 5'd29) || (x == 5'd30)));
  endfunction

  // Encodes one octet at the given RD; returns {rd_after, abcdei, fghj}.
  function automatic logic [10:0] encode_octet(input logic [7:0] octet,
                                               input logic       is_k,
                                               input logic       rd_in);
    logic [4:0] x;
    logic [2:0] y;
    logic [5:0] c6;
    logic [3:0] c4;
    logic       rd6;
    logic       rd4;
    logic       alt7;
    x = octet[4:0];
    y = octet[7:5];
    // RD- column of the 5b/6b table; the RD+ column is its complement
    // for unbalanced codes and for D.7.
    case (x)
      5'd0:    c6 = 6'b100111;
      5'd1:    c6 = 6'b011101;
      5'd2:    c6 = 6'b101101;
      5'd3:    c6 = 6'b110001;
      5'd4:    c6 = 6'b110101;
      5'd5:    c6 = 6'b101001;
      5'd6:    c6 = 6'b011001;
      5'd7:    c6 = 6'b111000;
      5'd8:    c6 = 6'b111001;
      5'd9:    c6 = 6'b100101;
      5'd10:   c6 = 6'b010101;
      5'd11:   c6 = 6'b110100;
      5'd12:   c6 = 6'b001101;
      5'd13:   c6 = 6'b101100;
      5'd14:   c6 = 6'b011100;
      5'd15:   c6 = 6'b010111;
      5'd16:   c6 = 6'b011011;
      5'd17:   c6 = 6'b100011;
      5'd18:   c6 = 6'b010011;
      5'd19:   c6 = 6'b110010;
      5'd20:   c6 = 6'b001011;
      5'd21:   c6 = 6'b101010;
      5'd22:   c6 = 6'b011010;
      5'd23:   c6 = 6'b111010;
      5'd24:   c6 = 6'b110011;
      5'd25:   c6 = 6'b100110;
      5'd26:   c6 = 6'b010110;
      5'd27:   c6 = 6'b110110;
      5'd28:   c6 = 6'b001110;
      5'd29:   c6 = 6'b101110;
      5'd30:   c6 = 6'b011110;
      default: c6 = 6'b101011;
    endcase
    if (is_k && (x == 5'd28)) c6 = 6'b001111;
    if (rd_in && (($countones(c6) != 3) || (x == 5'd7))) c6 = ~c6;
    rd6 = rd_in ^ ($countones(c6) != 3);
    // Alternate x.7 avoids a run of five equal bits across the sub-block boundary.
    alt7 = (!rd6 && ((x == 5'd17) || (x == 5'd18) || (x == 5'd20))) ||
           ( rd6 && ((x == 5'd11) || (x == 5'd13) || (x == 5'd14)));
    if (is_k) begin
      case (y)
        3'd0:    c4 = 4'b1011;
        3'd1:    c4 = 4'b0110;
        3'd2:    c4 = 4'b1010;
        3'd3:    c4 = 4'b1100;
        3'd4:    c4 = 4'b1101;
        3'd5:    c4 = 4'b0101;
        3'd6:    c4 = 4'b1001;
        default: c4 = 4'b0111;
      endcase
    end else begin
      case (y)
        3'd0:    c4 = 4'b1011;
        3'd1:    c4 = 4'b1001;
        3'd2:    c4 = 4'b0101;
        3'd3:    c4 = 4'b1100;
        3'd4:    c4 = 4'b1101;
        3'd5:    c4 = 4'b1010;
        3'd6:    c4 = 4'b0110;
        default: c4 = alt7 ? 4'b0111 : 4'b1110;
      endcase
    end
    // K codes are fully complemented at RD+; data only where the code is unbalanced or x.3.
    if (rd6 && (is_k || (y == 3'd0) || (y == 3'd3) || (y == 3'd4) || (y == 3'd7)))
      c4 = ~c4;
    rd4 = rd6 ^ ($countones(c4) != 2);
    return {rd4, c6, c4};
  endfunction

  logic                rd_q;
  logic                rd_start;
  logic                rd_run;
  logic                rd_end;
  logic [7:0]          octet;
  logic                kflag;
  logic [10:0]         sym;
  logic [10*BYTES-1:0] enc_data;
  logic [BYTES-1:0]    enc_kerr;

  logic                s1_valid;
  logic [10*BYTES-1:0] s1_data;
  logic [BYTES-1:0]    s1_kerr;
  logic                s1_rd;

`ifdef ENC_RD_LOAD_EN
  assign rd_start = i_rd_load ? i_rd_value : rd_q;
`else
  assign rd_start = rd_q;
`endif

  // Disparity chain: encode byte 0 first, each byte starting from the previous byte's RD.
  always_comb begin
    enc_data = '0;
    enc_kerr = '0;
    octet    = 8'h00;
    kflag    = 1'b0;
    sym      = '0;
    rd_run   = rd_start;
    for (int n = 0; n < BYTES; n++) begin
      octet = i_data[8*n +: 8];
      kflag = i_k[n];
      if (kflag && !k_is_legal(octet)) begin
        enc_kerr[n] = 1'b1;
        octet       = 8'hBC;
      end
      sym                = encode_octet(octet, kflag, rd_run);
      enc_data[10*n +: 10] = sym[9:0];
      rd_run             = sym[10];
    end
    rd_end = rd_run;
  end

  // Running disparity register; advances only when a word is accepted.
  always_ff @(posedge clk) begin
    if (!rst_n)       rd_q <= 1'b0;
    else if (i_valid) rd_q <= rd_end;
    else              rd_q <= rd_start;
  end

  // First output stage; data, error flags and RD hold through bubbles.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_data  <= '0;
      s1_kerr  <= '0;
      s1_rd    <= 1'b0;
    end else begin
      s1_valid <= i_valid;
      if (i_valid) begin
        s1_data <= enc_data;
        s1_kerr <= enc_kerr;
        s1_rd   <= rd_end;
      end
    end
  end

  generate
    if (REG_OUT != 0) begin : g_reg_out
      logic                s2_valid;
      logic [10*BYTES-1:0] s2_data;
      logic [BYTES-1:0]    s2_kerr;
      logic                s2_rd;

      // Extra retiming stage toward the serializer, same hold behaviour as stage 1.
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          s2_valid <= 1'b0;
          s2_data  <= '0;
          s2_kerr  <= '0;
          s2_rd    <= 1'b0;
        end else begin
          s2_valid <= s1_valid;
          if (s1_valid) begin
            s2_data <= s1_data;
            s2_kerr <= s1_kerr;
            s2_rd   <= s1_rd;
          end
        end
      end

      assign o_valid   = s2_valid;
      assign o_data    = s2_data;
      assign o_k_error = s2_kerr;
      assign o_rd      = s2_rd;
    end else begin : g_no_reg_out
      assign o_valid   = s1_valid;
      assign o_data    = s1_data;
      assign o_k_error = s1_kerr;
      assign o_rd      = s1_rd;
    end
  endgenerate

endmodule

// File: tb/tb_enc8b10b_lane.sv
// tb_enc8b10b_lane: directed bench for enc8b10b_lane.
// b1 = one byte per word with the output register; b2 = two bytes, no output register.
// Expected symbols are hand-encoded from the 8b/10b tables (abcdeifghj, a = MSB).

module tb_enc8b10b_lane;

  logic        clk = 1'b0;
  logic        rst_n;

  logic        b1_valid;
  logic [7:0]  b1_data;
  logic [0:0]  b1_k;
  logic        b1_ovalid;
  logic [9:0]  b1_odata;
  logic [0:0]  b1_kerr;
  logic        b1_rd;

  logic        b2_valid;
  logic [15:0] b2_data;
  logic [1:0]  b2_k;
  logic        b2_ovalid;
  logic [19:0] b2_odata;
  logic [1:0]  b2_kerr;
  logic        b2_rd;

  logic        rd_load;
  logic        rd_value;
  logic        tie_low;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  enc8b10b_lane #(.BYTES(1), .REG_OUT(1)) u_b1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_valid   (b1_valid),
    .i_data    (b1_data),
    .i_k       (b1_k),
`ifdef ENC_RD_LOAD_EN
    .i_rd_load (rd_load),
    .i_rd_value(rd_value),
`endif
    .o_valid   (b1_ovalid),
    .o_data    (b1_odata),
    .o_k_error (b1_kerr),
    .o_rd      (b1_rd)
  );

  enc8b10b_lane #(.BYTES(2), .REG_OUT(0)) u_b2 (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_valid   (b2_valid),
    .i_data    (b2_data),
    .i_k       (b2_k),
`ifdef ENC_RD_LOAD_EN
    .i_rd_load (tie_low),
    .i_rd_value(tie_low),
`endif
    .o_valid   (b2_ovalid),
    .o_data    (b2_odata),
    .o_k_error (b2_kerr),
    .o_rd      (b2_rd)
  );

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  // Present one word to b1 for a single cycle and wait out the two-cycle latency.
  task automatic applyStimulus(input logic [7:0] d, input logic k);
    b1_valid = 1'b1;
    b1_data  = d;
    b1_k     = k;
    @(negedge clk);
    b1_valid = 1'b0;
    @(negedge clk);
  endtask

  // Encode one word on b1 and compare the full output set.
  task automatic encodeWord(input string tag, input logic [7:0] d, input logic k,
                            input logic [9:0] sym, input logic rd, input logic kerr);
    applyStimulus(d, k);
    checkOutput({tag, "_valid"}, 32'(b1_ovalid), 32'(1'b1));
    checkOutput({tag, "_data"},  32'(b1_odata),  32'(sym));
    checkOutput({tag, "_rd"},    32'(b1_rd),     32'(rd));
    checkOutput({tag, "_kerr"},  32'(b1_kerr),   32'(kerr));
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_n    = 1'b0;
    b1_valid = 1'b0; b1_data = '0; b1_k = '0;
    b2_valid = 1'b0; b2_data = '0; b2_k = '0;
    rd_load  = 1'b0; rd_value = 1'b0; tie_low = 1'b0;
    repeat (2) @(negedge clk);

    checkOutput("rst_b1_valid", 32'(b1_ovalid), 32'd0);
    checkOutput("rst_b1_data",  32'(b1_odata),  32'd0);
    checkOutput("rst_b1_kerr",  32'(b1_kerr),   32'd0);
    checkOutput("rst_b1_rd",    32'(b1_rd),     32'd0);
    checkOutput("rst_b2_valid", 32'(b2_ovalid), 32'd0);
    checkOutput("rst_b2_data",  32'(b2_odata),  32'd0);
    rst_n = 1'b1;

    // Back-to-back K28.5 on b1: latency exactly two cycles, RD alternates.
    b1_valid = 1'b1; b1_data = 8'hBC; b1_k = 1'b1;
    @(negedge clk);
    checkOutput("k285_lat1_valid", 32'(b1_ovalid), 32'd0);
    @(negedge clk);
    b1_valid = 1'b0;
    checkOutput("k285a_valid", 32'(b1_ovalid), 32'd1);
    checkOutput("k285a_data",  32'(b1_odata),  32'(10'b0011111010));
    checkOutput("k285a_rd",    32'(b1_rd),     32'd1);
    @(negedge clk);
    checkOutput("k285b_valid", 32'(b1_ovalid), 32'd1);
    checkOutput("k285b_data",  32'(b1_odata),  32'(10'b1100000101));
    checkOutput("k285b_rd",    32'(b1_rd),     32'd0);
    @(negedge clk);
    checkOutput("bubble_valid", 32'(b1_ovalid), 32'd0);
    checkOutput("bubble_hold",  32'(b1_odata),  32'(10'b1100000101));

    // b2: K28.5 K28.5 chained within one word from RD-.
    b2_valid = 1'b1; b2_data = 16'hBCBC; b2_k = 2'b11;
    @(negedge clk);
    b2_valid = 1'b0;
    checkOutput("b2kk_valid", 32'(b2_ovalid),        32'd1);
    checkOutput("b2kk_sym0",  32'(b2_odata[9:0]),   32'(10'b0011111010));
    checkOutput("b2kk_sym1",  32'(b2_odata[19:10]), 32'(10'b1100000101));
    checkOutput("b2kk_rd",    32'(b2_rd),            32'd0);
    checkOutput("b2kk_kerr",  32'(b2_kerr),          32'd0);

    // b2: D17.7 (A7) then an illegal K in byte 1, substituted at RD+.
    b2_valid = 1'b1; b2_data = 16'h00F1; b2_k = 2'b10;
    @(negedge clk);
    b2_valid = 1'b0;
    checkOutput("b2mix_sym0", 32'(b2_odata[9:0]),   32'(10'b1000110111));
    checkOutput("b2mix_sym1", 32'(b2_odata[19:10]), 32'(10'b1100000101));
    checkOutput("b2mix_kerr", 32'(b2_kerr),          32'(2'b10));
    checkOutput("b2mix_rd",   32'(b2_rd),            32'd0);
    @(negedge clk);
    checkOutput("b2hold_valid", 32'(b2_ovalid), 32'd0);
    checkOutput("b2hold_kerr",  32'(b2_kerr),   32'(2'b10));

    // b1 data codes from RD-.
    encodeWord("d00",  8'h00, 1'b0, 10'b1001110100, 1'b0, 1'b0);
    encodeWord("d215", 8'hB5, 1'b0, 10'b1010101010, 1'b0, 1'b0);
    encodeWord("d177", 8'hF1, 1'b0, 10'b1000110111, 1'b1, 1'b0);
    encodeWord("d207", 8'hF4, 1'b0, 10'b0010110001, 1'b0, 1'b0);
    encodeWord("badk", 8'h00, 1'b1, 10'b0011111010, 1'b1, 1'b1);
    encodeWord("d00p", 8'h00, 1'b0, 10'b0110001011, 1'b1, 1'b0);

    // Mid-stream reset at RD+: in-flight word dropped, RD back to RD-.
    b1_valid = 1'b1; b1_data = 8'hB5; b1_k = 1'b0;
    @(negedge clk);
    rst_n = 1'b0; b1_data = 8'hBC; b1_k = 1'b1;
    @(negedge clk);
    checkOutput("mrst_valid", 32'(b1_ovalid), 32'd0);
    checkOutput("mrst_data",  32'(b1_odata),  32'd0);
    checkOutput("mrst_rd",    32'(b1_rd),     32'd0);
    rst_n = 1'b1; b1_valid = 1'b0;
    @(negedge clk);
    checkOutput("mrst_drop", 32'(b1_ovalid), 32'd0);
    encodeWord("mrst_k285", 8'hBC, 1'b1, 10'b0011111010, 1'b1, 1'b0);

`ifdef ENC_RD_LOAD_EN
    encodeWord("pre_load", 8'hBC, 1'b1, 10'b1100000101, 1'b0, 1'b0);
    // Load RD+ together with a K28.5 word.
    rd_load = 1'b1; rd_value = 1'b1;
    b1_valid = 1'b1; b1_data = 8'hBC; b1_k = 1'b1;
    @(negedge clk);
    rd_load = 1'b0; b1_valid = 1'b0;
    @(negedge clk);
    checkOutput("load_data", 32'(b1_odata), 32'(10'b1100000101));
    checkOutput("load_rd",   32'(b1_rd),    32'd0);
    // Load on an idle cycle, then encode.
    rd_load = 1'b1; rd_value = 1'b1;
    @(negedge clk);
    rd_load = 1'b0;
    encodeWord("idle_load", 8'hBC, 1'b1, 10'b1100000101, 1'b0, 1'b0);
    // Reset beats a simultaneous load.
    rst_n = 1'b0; rd_load = 1'b1; rd_value = 1'b1;
    @(negedge clk);
    rst_n = 1'b1; rd_load = 1'b0;
    encodeWord("rst_over_load", 8'hBC, 1'b1, 10'b0011111010, 1'b1, 1'b0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
